// File: rtl/uart_rx_fsm.sv
// uart_rx_fsm: 8N1 UART receiver driving the clk_div baud divider; even parity when UART_RX_PARITY_EN is defined.
module uart_rx_fsm #(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_i,
    input  logic              baud_tick,
    output logic              cnt_en,
    output logic              half_bit,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              frame_err,
`ifdef UART_RX_PARITY_EN
    output logic              parity_err,
`endif
    output logic              busy
);
    localparam int CW = $clog2(DATA_W) + 1;
    localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, PARITY} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t                 state;
    logic [SYNC_STAGES-1:0] sync;
    logic                   rx_prev;
    logic [DATA_W-1:0]      shift;
    logic [CW-1:0]          bit_cnt;
    logic                   rx_s;
`ifdef UART_RX_PARITY_EN
    logic                   par_bit;
    logic                   par_bad;
    assign par_bad = ^{shift, par_bit};
`endif

    assign rx_s     = sync[SYNC_STAGES-1];
    assign cnt_en   = state != IDLE;
    assign busy     = state != IDLE;
    assign half_bit = state == START;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            sync      <= '1;
            rx_prev   <= 1'b1;
            shift     <= '0;
            bit_cnt   <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit    <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            sync      <= {sync[SYNC_STAGES-2:0], rx_i};
            rx_prev   <= rx_s;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
            case (state)
                // a held-low line keeps rx_prev low, so only a high-to-low edge starts a frame
                IDLE: if (rx_prev && !rx_s) state <= START;
                START: if (baud_tick) begin
                    state   <= rx_s ? IDLE : DATA;
                    bit_cnt <= '0;
                end
                DATA: if (baud_tick) begin
                    shift   <= {rx_s, shift[DATA_W-1:1]};
                    bit_cnt <= (bit_cnt == LAST) ? bit_cnt : bit_cnt + 1'b1;
`ifdef UART_RX_PARITY_EN
                    if (bit_cnt == LAST) state <= PARITY;
`else
                    if (bit_cnt == LAST) state <= STOP;
`endif
                end
`ifdef UART_RX_PARITY_EN
                PARITY: if (baud_tick) begin
                    par_bit <= rx_s;
                    state   <= STOP;
                end
                STOP: if (baud_tick) begin
                    state      <= IDLE;
                    frame_err  <= !rx_s;
                    rx_valid   <= rx_s && !par_bad;
                    parity_err <= rx_s && par_bad;
                    if (rx_s && !par_bad) rx_data <= shift;
                end
`else
                STOP: if (baud_tick) begin
                    state     <= IDLE;
                    frame_err <= !rx_s;
                    rx_valid  <= rx_s;
                    if (rx_s) rx_data <= shift;
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx_fsm.sv
// tb_uart_rx_fsm: directed bench for uart_rx_fsm with a behavioural clk_div (MAX_CNT=16); parity cases under UART_RX_PARITY_EN.
module tb_uart_rx_fsm;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rx_i = 1'b1;
    logic       baud_tick;
    logic       cnt_en, half_bit, rx_valid, frame_err, busy;
    logic [7:0] rx_data;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
`endif

    uart_rx_fsm #(.DATA_W(8), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .rx_i(rx_i), .baud_tick(baud_tick),
        .cnt_en(cnt_en), .half_bit(half_bit), .rx_data(rx_data),
        .rx_valid(rx_valid), .frame_err(frame_err),
`ifdef UART_RX_PARITY_EN
        .parity_err(parity_err),
`endif
        .busy(busy)
    );

    always #5 clk = ~clk;

    // divider: 16 clk per full bit, 8 per half bit, cleared while cnt_en is low
    logic [4:0] div_cnt = '0;
    assign baud_tick = cnt_en && (div_cnt == (half_bit ? 5'd7 : 5'd15));
    always @(posedge clk) div_cnt <= (!cnt_en || baud_tick) ? 5'd0 : div_cnt + 5'd1;

    int         vcnt = 0, fcnt = 0, pcnt = 0, vrun = 0, vmax = 0, busy_bad = 0, both = 0;
    logic [7:0] got[$];
    always @(negedge clk) begin
        if (rx_valid) begin
            vcnt++;
            got.push_back(rx_data);
            if (busy) busy_bad++;
        end
        if (frame_err) fcnt++;
        if (rx_valid && frame_err) both++;
`ifdef UART_RX_PARITY_EN
        if (parity_err) pcnt++;
`endif
        vrun = rx_valid ? vrun + 1 : 0;
        if (vrun > vmax) vmax = vrun;
    end

    int passed = 0, total = 0;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic bit_out(input logic b, input int n);
        rx_i = b;
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] d, input logic stop, input logic par);
        bit_out(1'b0, 16);
        for (int i = 0; i < 8; i++) bit_out(d[i], 16);
`ifdef UART_RX_PARITY_EN
        bit_out(par, 16);
`else
        if (par) rx_i = 1'b1;
`endif
        bit_out(stop, 16);
    endtask

    int v0, f0, p0, n0;
    logic [7:0] partial;
    initial begin
        repeat (3) @(negedge clk);
        chk("rst_rx_data", rx_data, 0);
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_frame_err", frame_err, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cnt_en", cnt_en, 0);
        chk("rst_half_bit", half_bit, 0);
        rst = 1'b1;
        repeat (5) @(negedge clk);

        v0 = vcnt; f0 = fcnt;
        send(8'hA5, 1'b1, 1'b0);
        bit_out(1'b1, 20);
        chk("t1_valid_count", vcnt - v0, 1);
        chk("t1_rx_data", rx_data, 8'hA5);
        chk("t1_frame_err", fcnt - f0, 0);
        chk("t1_busy_idle", busy, 0);
        chk("t1_cnt_en_idle", cnt_en, 0);

        v0 = vcnt; f0 = fcnt;
        bit_out(1'b0, 4);
        bit_out(1'b1, 2);
        chk("t2_busy_start", busy, 1);
        chk("t2_half_bit", half_bit, 1);
        bit_out(1'b1, 20);
        chk("t2_cnt_en_back", cnt_en, 0);
        chk("t2_no_strobe", (vcnt - v0) + (fcnt - f0), 0);

        v0 = vcnt; f0 = fcnt;
        send(8'h3C, 1'b0, 1'b0);
        bit_out(1'b0, 64);
        chk("t3_frame_err", fcnt - f0, 1);
        chk("t3_no_valid", vcnt - v0, 0);
        chk("t3_rx_data_kept", rx_data, 8'hA5);
        chk("t3_break_idle", busy, 0);
        bit_out(1'b1, 20);
        chk("t3_no_retrigger", busy + (vcnt - v0) + (fcnt - f0 - 1), 0);

        v0 = vcnt; n0 = got.size();
        send(8'h00, 1'b1, 1'b0);
        send(8'hFF, 1'b1, 1'b0);
        send(8'h81, 1'b1, 1'b1);
        bit_out(1'b1, 20);
        chk("t4_valid_count", vcnt - v0, 3);
        chk("t4_first", got[n0], 8'h00);
        chk("t4_second", got[n0+1], 8'hFF);
        chk("t4_third", got[n0+2], 8'h81);

        partial = 8'h96;
        bit_out(1'b0, 16);
        for (int i = 0; i < 4; i++) bit_out(partial[i], 16);
        bit_out(partial[4], 8);
        rst = 1'b0;
        rx_i = 1'b1;
        @(negedge clk);
        chk("t5_rx_data", rx_data, 0);
        chk("t5_busy", busy, 0);
        chk("t5_cnt_en", cnt_en, 0);
        chk("t5_half_bit", half_bit, 0);
        chk("t5_flags", {rx_valid, frame_err}, 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        bit_out(1'b1, 10);
        v0 = vcnt; f0 = fcnt;
        send(8'h5A, 1'b1, 1'b0);
        bit_out(1'b1, 20);
        chk("t5_valid_count", vcnt - v0, 1);
        chk("t5_rx_data_after", rx_data, 8'h5A);
        chk("t5_no_frame_err", fcnt - f0, 0);

`ifdef UART_RX_PARITY_EN
        v0 = vcnt; p0 = pcnt;
        send(8'h07, 1'b1, 1'b1);
        bit_out(1'b1, 20);
        chk("t6_good_valid", vcnt - v0, 1);
        chk("t6_good_data", rx_data, 8'h07);
        chk("t6_good_no_perr", pcnt - p0, 0);
        v0 = vcnt; p0 = pcnt;
        send(8'h07, 1'b1, 1'b0);
        bit_out(1'b1, 20);
        chk("t6_bad_perr", pcnt - p0, 1);
        chk("t6_bad_no_valid", vcnt - v0, 0);
        v0 = vcnt; p0 = pcnt; f0 = fcnt;
        send(8'h07, 1'b0, 1'b0);
        bit_out(1'b1, 20);
        chk("t6_both_frame_err", fcnt - f0, 1);
        chk("t6_both_no_perr", pcnt - p0, 0);
`endif

        chk("pulse_width_max", vmax, 1);
        chk("busy_with_strobe", busy_bad, 0);
        chk("valid_frame_excl", both, 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
